dice_digit_scanner: RTL

Upstream feeder for the 7-segment digit decoder. Takes an 8-bit dice result, converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits. Each scan slot presents one 4-bit digit to the decoder, plus a one-hot digit enable and a leading-zero blank flag. Sits between the dice roll logic and the segment decoder and pad outputs.

---
 rtl/dice_disp_pkg.sv | 24 ++
 rtl/dice_digit_scanner_if.sv | 15 +
 rtl/bin2bcd_seq.sv | 56 +++++
 rtl/dice_digit_scanner.sv | 66 ++++++
 4 files changed

// File: rtl/dice_disp_pkg.sv
// rtl/dice_disp_pkg.sv - shared widths, slot indices, conversion states and BCD helper
package dice_disp_pkg;

    localparam int NDIG  = 3;
    localparam int BCD_W = 12;
    localparam int VAL_W = 8;

    localparam logic [1:0] SLOT_ONES     = 2'd0;
    localparam logic [1:0] SLOT_TENS     = 2'd1;
    localparam logic [1:0] SLOT_HUNDREDS = 2'd2;

    typedef enum logic {IDLE, CONV} conv_state_t;

    // Double-dabble correction: each nibble is adjusted on its own, no carry between nibbles
    function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            r[i*4 +: 4] = (s[i*4 +: 4] >= 4'd5) ? s[i*4 +: 4] + 4'd3 : s[i*4 +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/dice_digit_scanner_if.sv
// rtl/dice_digit_scanner_if.sv - load request and multiplexed digit bundle
interface dice_digit_scanner_if;
    import dice_disp_pkg::*;

    logic [VAL_W-1:0] value;
    logic             load;
    logic             busy;
    logic [BCD_W-1:0] bcd;
    logic [3:0]       digit;
    logic [NDIG-1:0]  digit_en;
    logic             blank;

    modport master (output value, load, input busy, bcd, digit, digit_en, blank);
    modport slave  (input value, load, output busy, bcd, digit, digit_en, blank);
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - 8-iteration shift-add-3 binary to BCD converter
module bin2bcd_seq
    import dice_disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [VAL_W-1:0] value,
    input  logic             load,
    output logic             busy,
    output logic [BCD_W-1:0] bcd
);

    conv_state_t            state;
    logic [VAL_W-1:0]       shreg;
    logic [BCD_W-1:0]       scratch;
    logic [2:0]             iter;
    logic [BCD_W+VAL_W-1:0] shifted;

    assign shifted = {add3_nibbles(scratch), shreg} << 1;

    // bcd only moves on the final iteration so the display never sees partial results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            shreg   <= '0;
            scratch <= '0;
            iter    <= '0;
            bcd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg   <= value;
                        scratch <= '0;
                        iter    <= '0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    scratch <= shifted[BCD_W+VAL_W-1:VAL_W];
                    shreg   <= shifted[VAL_W-1:0];
                    iter    <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        bcd   <= shifted[BCD_W+VAL_W-1:VAL_W];
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dice_digit_scanner.sv
// rtl/dice_digit_scanner.sv - BCD conversion plus time-multiplexed digit scan with leading-zero blanking
module dice_digit_scanner
    import dice_disp_pkg::*;
#(
    parameter int SCAN_DIV = 1024,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dice_digit_scanner_if.slave  bus
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [BCD_W-1:0] bcd_q;
    logic [PW-1:0]    presc;
    logic [1:0]       slot;
    logic             hund_zero;
    logic             tens_zero;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .value (bus.value),
        .load  (bus.load),
        .busy  (bus.busy),
        .bcd   (bcd_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            slot  <= SLOT_ONES;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            slot  <= (slot == SLOT_HUNDREDS) ? SLOT_ONES : slot + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign hund_zero = (bcd_q[11:8] == 4'd0);
    assign tens_zero = (bcd_q[7:4] == 4'd0);

    // Ones slot is never blanked so a zero result still shows "0"
    always_comb begin
        bus.digit = bcd_q[3:0];
        bus.blank = 1'b0;
        case (slot)
            SLOT_TENS: begin
                bus.digit = bcd_q[7:4];
                bus.blank = hund_zero && tens_zero;
            end
            SLOT_HUNDREDS: begin
                bus.digit = bcd_q[11:8];
                bus.blank = hund_zero;
            end
            default: ;
        endcase
        if (!LZ_BLANK) bus.blank = 1'b0;
    end

    assign bus.digit_en = NDIG'(1) << slot;
    assign bus.bcd      = bcd_q;

endmodule
